// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier, the product accumulator and its consumer.
// The master modport is the side that feeds products in and takes results out.
interface product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, in_last, abort, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, abort, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums a burst of unsigned products into one wrapped total with beat count and a
// sticky carry flag, then holds the result on a valid/ready handshake until taken.
module product_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 12,
  parameter int MAX_BEATS = 15,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [ACC_W-1:0]  acc, acc_d;
  logic [CNT_W-1:0]  count, count_d;
  logic              ovf, ovf_d;

  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum_ext;
  logic [CNT_W-1:0]  count_inc;
  logic              accept;
  logic              take;

  // Handshake qualifiers are decoded from registered state, so no input reaches an output.
  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = acc;
  assign bus.out_count = count;
  assign bus.out_ovf   = ovf;

  assign prod      = bus.in_prod;
  assign accept    = bus.in_valid & bus.in_ready;
  assign take      = bus.out_valid & bus.out_ready;
  assign sum_ext   = {1'b0, acc} + (ACC_W+1)'(prod);
  assign count_inc = count + CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state;
    acc_d   = acc;
    count_d = count;
    ovf_d   = ovf;

    unique case (state)
      IDLE: begin
        if (accept) begin
          acc_d   = ACC_W'(prod);
          count_d = CNT_W'(1);
          ovf_d   = 1'b0;
          if (bus.in_last || (MAX_BEATS == 1)) state_d = DONE;
          else                                 state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = sum_ext[ACC_W-1:0];
          count_d = count_inc;
          ovf_d   = ovf | sum_ext[ACC_W];
          if (bus.in_last || (count_inc == CNT_W'(MAX_BEATS))) state_d = DONE;
        end
      end
      DONE: begin
        if (take) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end
    endcase

    // Abort outranks any beat or take in the same cycle.
    if (bus.abort) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all of them update together.
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      count <= count_d;
      ovf   <= ovf_d;
    end
  end

endmodule
